// File: rtl/hazard3_domain_pwr_seq.sv
// Power-domain sequencer answering the pwrup_req/pwrup_ack 4-phase handshake.
// Orders power switch, clock enable, reset and isolation for domain up/down.
module hazard3_domain_pwr_seq #(
  parameter int W_CNT      = 8,
  parameter int PWR_SETTLE = 4,
  parameter int RST_HOLD   = 4,
  parameter int ISO_DELAY  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwrup_req,
  output logic pwrup_ack,
  input  logic pwr_good,
  output logic pwr_en,
  output logic dom_clk_en,
  output logic dom_rst,
  output logic iso_en,
  output logic pwr_fault
);

  typedef enum logic [3:0] {
    S_ON,
    S_ISO_ON,
    S_RST_ON,
    S_CLK_OFF,
    S_PWR_DOWN,
    S_OFF,
    S_PWR_UP,
    S_PWR_SETTLE,
    S_CLK_UP,
    S_RST_REL
  } state_t;

  localparam logic [W_CNT-1:0] SETTLE_LD = W_CNT'(PWR_SETTLE - 1);
  localparam logic [W_CNT-1:0] RST_LD    = W_CNT'(RST_HOLD - 1);
  localparam logic [W_CNT-1:0] ISO_LD    = W_CNT'(ISO_DELAY - 1);

  state_t           state_reg, state_next;
  logic [W_CNT-1:0] cnt_reg, cnt_next;
  logic [1:0]       sync_reg;
  // {pwr_en, dom_clk_en, dom_rst, iso_en, pwrup_ack}
  logic [4:0]       out_reg, out_next;
  logic             fault_reg, fault_next;
  logic             good_s;
  logic             cnt_zero;

  assign good_s   = sync_reg[1];
  assign cnt_zero = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_ON: begin
        if (!pwrup_req) begin
          state_next = S_ISO_ON;
          cnt_next   = ISO_LD;
        end
      end
      S_ISO_ON: begin
        if (cnt_zero) begin
          state_next = S_RST_ON;
          cnt_next   = RST_LD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_RST_ON: begin
        if (cnt_zero) state_next = S_CLK_OFF;
        else          cnt_next   = cnt_reg - 1'b1;
      end
      S_CLK_OFF: state_next = S_PWR_DOWN;
      S_PWR_DOWN: begin
        if (!good_s) state_next = S_OFF;
      end
      S_OFF: begin
        if (pwrup_req) state_next = S_PWR_UP;
      end
      S_PWR_UP: begin
        if (good_s) begin
          state_next = S_PWR_SETTLE;
          cnt_next   = SETTLE_LD;
        end
      end
      S_PWR_SETTLE: begin
        if (cnt_zero) begin
          state_next = S_CLK_UP;
          cnt_next   = RST_LD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_CLK_UP: begin
        if (cnt_zero) begin
          state_next = S_RST_REL;
          cnt_next   = ISO_LD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_RST_REL: begin
        if (cnt_zero) state_next = S_ON;
        else          cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = S_ON;
    endcase
  end

  // Outputs are decoded from the next state so they flip on the entry edge.
  always_comb begin
    out_next = 5'b11001;
    case (state_next)
      S_ON:         out_next = 5'b11001;
      S_ISO_ON:     out_next = 5'b11011;
      S_RST_ON:     out_next = 5'b11111;
      S_CLK_OFF:    out_next = 5'b10111;
      S_PWR_DOWN:   out_next = 5'b00111;
      S_OFF:        out_next = 5'b00110;
      S_PWR_UP:     out_next = 5'b10110;
      S_PWR_SETTLE: out_next = 5'b10110;
      S_CLK_UP:     out_next = 5'b11110;
      S_RST_REL:    out_next = 5'b11010;
      default:      out_next = 5'b11001;
    endcase
  end

  always_comb begin
    fault_next = fault_reg;
    case (state_reg)
      S_ON, S_ISO_ON, S_RST_ON, S_CLK_OFF, S_PWR_SETTLE, S_CLK_UP, S_RST_REL:
        if (!good_s) fault_next = 1'b1;
      default: fault_next = fault_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_ON;
      cnt_reg   <= '0;
      sync_reg  <= 2'b11;
      out_reg   <= 5'b11001;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sync_reg  <= {sync_reg[0], pwr_good};
      out_reg   <= out_next;
      fault_reg <= fault_next;
    end
  end

  assign pwr_en     = out_reg[4];
  assign dom_clk_en = out_reg[3];
  assign dom_rst    = out_reg[2];
  assign iso_en     = out_reg[1];
  assign pwrup_ack  = out_reg[0];
  assign pwr_fault  = fault_reg;

endmodule

// File: tb/tb_hazard3_domain_pwr_seq.sv
// Directed bench for hazard3_domain_pwr_seq with pwr_good looped back from pwr_en.
module tb_hazard3_domain_pwr_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwrup_req = 1'b1;
  logic pwrup_ack;
  logic pwr_good;
  logic pwr_en, dom_clk_en, dom_rst, iso_en, pwr_fault;
  logic loop_en = 1'b1;
  logic good_drv = 1'b1;
  logic inv_on = 1'b0;

  int checks = 0;
  int errors = 0;

  assign pwr_good = loop_en ? pwr_en : good_drv;

  hazard3_domain_pwr_seq dut (
    .clk        (clk),
    .rst        (rst),
    .pwrup_req  (pwrup_req),
    .pwrup_ack  (pwrup_ack),
    .pwr_good   (pwr_good),
    .pwr_en     (pwr_en),
    .dom_clk_en (dom_clk_en),
    .dom_rst    (dom_rst),
    .iso_en     (iso_en),
    .pwr_fault  (pwr_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // {pwr_fault, pwr_en, dom_clk_en, dom_rst, iso_en, pwrup_ack}
  function automatic logic [7:0] obs();
    return {2'b00, pwr_fault, pwr_en, dom_clk_en, dom_rst, iso_en, pwrup_ack};
  endfunction

  // Expected outputs at edge n of a power-down, n=0 being the edge that samples req=0.
  function automatic logic [7:0] exp_down(input int n);
    if (n >= 10) return 8'b000_00110;
    if (n >= 7)  return 8'b000_00111;
    if (n >= 6)  return 8'b000_10111;
    if (n >= 2)  return 8'b000_11111;
    return 8'b000_11011;
  endfunction

  // Expected outputs at edge n of a power-up, n=0 being the edge that samples req=1.
  function automatic logic [7:0] exp_up(input int n);
    if (n >= 13) return 8'b000_11001;
    if (n >= 11) return 8'b000_11010;
    if (n >= 7)  return 8'b000_11110;
    return 8'b000_10110;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      check("inv_order",
            {7'd0, ((!(dom_rst || !dom_clk_en)) || iso_en) &&
                   (dom_clk_en || dom_rst) &&
                   (!dom_clk_en || pwr_en)},
            8'd1);
    end
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    inv_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("reset_hold", obs(), 8'b000_11001);
    end
    $display("reset phase: outputs held for 20 cycles");

    pwrup_req = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      step();
      check($sformatf("down_e%0d", n), obs(), exp_down(n));
    end
    $display("power-down phase: ack low at edge 10");

    pwrup_req = 1'b1;
    for (int n = 0; n <= 13; n++) begin
      step();
      check($sformatf("up_e%0d", n), obs(), exp_up(n));
    end
    $display("power-up phase: ack high at edge 13");

    pwrup_req = 1'b0;
    for (int n = 0; n <= 24; n++) begin
      step();
      check($sformatf("rev_e%0d", n), obs(), (n <= 10) ? exp_down(n) : exp_up(n - 11));
      if (n == 3) pwrup_req = 1'b1;
    end
    $display("reversal phase: ack low at 10, high at 24");

    loop_en  = 1'b0;
    good_drv = 1'b0;
    step();
    good_drv = 1'b1;
    check("fault_s0", obs(), 8'b000_11001);
    step();
    check("fault_s1", obs(), 8'b000_11001);
    step();
    check("fault_set", obs(), 8'b001_11001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("fault_sticky", obs(), 8'b001_11001);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    loop_en = 1'b1;
    check("fault_clear", obs(), 8'b000_11001);
    $display("fault phase: sticky fault cleared by reset");

    pwrup_req = 1'b0;
    for (int n = 0; n <= 10; n++) step();
    check("mid_pre_down", obs(), exp_down(10));
    pwrup_req = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      step();
      check($sformatf("mid_up_e%0d", n), obs(), exp_up(n));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset", obs(), 8'b000_11001);
    pwrup_req = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      step();
      check($sformatf("mid_down_e%0d", n), obs(), exp_down(n));
    end
    $display("mid-sequence reset phase: normal power-down afterwards");

    inv_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard3_domain_pwr_seq.md
# hazard3_domain_pwr_seq

Power-domain sequencer for the non-processor side of the 4-phase `pwrup_req`/`pwrup_ack` handshake driven by the Hazard3 power controller. It receives `pwrup_req` and sequences the domain's power switch, clock enable, reset and isolation in a fixed order. It then returns `pwrup_ack` once the domain is fully up or fully down. It runs on the always-on clock, alongside the core's power controller.

## Interface
Parameters:
- `W_CNT`, 8: width of the shared delay counter.
- `PWR_SETTLE`, 4: cycles to wait after power-good is seen before enabling the clock. Must be ≥1 and < 2^W_CNT.
- `RST_HOLD`, 4: cycles reset is held with the clock running. The same count is used on power-down. Must be ≥1.
- `ISO_DELAY`, 2: cycles between reset change and isolation change. Must be ≥1.

Ports:
- `clk`  in  1  always-on clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pwrup_req`  in  1  power-up request from the core power controller. Synchronous to `clk`.
- `pwrup_ack`  out  1  acknowledge. Follows `pwrup_req` only when a sequence completes.
- `pwr_good`  in  1  power-switch status. Asynchronous; passes through a 2-flop synchroniser internally.
- `pwr_en`  out  1  power-switch enable.
- `dom_clk_en`  out  1  clock-gate enable for the domain.
- `dom_rst`  out  1  domain reset, active-high.
- `iso_en`  out  1  output isolation enable, active-high.
- `pwr_fault`  out  1  sticky flag: power-good lost while the domain is required to be powered.

## Operation
- All outputs are flops. Each output takes its new value on the same edge that the state register enters the corresponding state. This keeps the outputs glitch-free.
- States and outputs (listed as `pwr_en`/`dom_clk_en`/`dom_rst`/`iso_en`/`pwrup_ack`):
  - ON = 1/1/0/0/1
  - ISO_ON = 1/1/0/1/1
  - RST_ON = 1/1/1/1/1
  - CLK_OFF = 1/0/1/1/1
  - PWR_DOWN = 0/0/1/1/1
  - OFF = 0/0/1/1/0
  - PWR_UP = 1/0/1/1/0
  - PWR_SETTLE = 1/0/1/1/0
  - CLK_UP = 1/1/1/1/0
  - RST_REL = 1/1/0/1/0
- Transitions:
  - ON: `pwrup_req`=0 → ISO_ON.
  - ISO_ON: after `ISO_DELAY` cycles → RST_ON.
  - RST_ON: after `RST_HOLD` cycles → CLK_OFF.
  - CLK_OFF: 1 cycle → PWR_DOWN.
  - PWR_DOWN: synchronised `pwr_good`=0 → OFF.
  - OFF: `pwrup_req`=1 → PWR_UP.
  - PWR_UP: synchronised `pwr_good`=1 → PWR_SETTLE.
  - PWR_SETTLE: after `PWR_SETTLE` cycles → CLK_UP.
  - CLK_UP: after `RST_HOLD` cycles → RST_REL.
  - RST_REL: after `ISO_DELAY` cycles → ON.
- Timed states: the counter loads N−1 on state entry and the state exits on the edge where the counter reads 0. The state is therefore occupied exactly N cycles.
- `pwrup_req` is sampled only in ON and OFF. Changes during a sequence are ignored; the sequence always runs to completion. If req ≠ ack on arrival at ON or OFF, the opposite sequence starts on the next edge.
- PWR_UP and PWR_DOWN have no timeout; they wait indefinitely.
- `pwr_fault`:
  - Sets when synchronised `pwr_good`=0 in ON, ISO_ON, RST_ON, CLK_OFF, PWR_SETTLE, CLK_UP or RST_REL.
  - Cleared only by `rst`.
  - Does not alter sequencing.

## Timing
- Reset, on the first edge with `rst`=1 and regardless of current state:
  - State = ON.
  - `pwrup_ack`=1, `pwr_en`=1, `dom_clk_en`=1, `dom_rst`=0, `iso_en`=0, `pwr_fault`=0.
  - Both synchroniser flops = 1, matching the core's reset-time assumption that ack is high.
  - Reset mid-sequence has the same effect. System integration guarantees `rst` also resets the domain.
- Synchroniser: a `pwr_good` edge is visible to the FSM 2 edges later, so PWR_UP and PWR_DOWN each last ≥1 cycle.
- Up latency with `pwr_good` tied to `pwr_en`: ack rises on edge 3+`PWR_SETTLE`+`RST_HOLD`+`ISO_DELAY`, counted from the edge that sampled req=1. With defaults this is 13.
- Down latency under the same model: ack falls on edge `ISO_DELAY`+`RST_HOLD`+4. With defaults this is 10.
- Ordering invariants, asserted in the bench:
  - `iso_en` is 1 whenever `dom_rst`=1 or `dom_clk_en`=0.
  - `dom_rst` is 1 whenever `dom_clk_en`=0.
  - `pwr_en` is 1 whenever `dom_clk_en`=1.

## Test plan
- **Reset value:** reset, `pwr_good`=1, `pwrup_req`=1 → ack=1, `pwr_en`=1, `dom_clk_en`=1, `dom_rst`=0, `iso_en`=0, `pwr_fault`=0; no change over 20 cycles.
- **Power-down, defaults, `pwr_good`=`pwr_en` loopback:** drop req → `iso_en` rises edge 0, `dom_rst` edge 2, `dom_clk_en` falls edge 6, `pwr_en` falls edge 7, ack=0 edge 10.
- **Power-up from OFF:** raise req → `pwr_en` edge 0, `dom_clk_en` edge 7, `dom_rst` falls edge 11, `iso_en` falls and ack=1 edge 13.
- **Req reversal mid-sequence:** drop req, re-raise at edge 3 → down sequence completes (ack=0 edge 10), up starts edge 11, ack=1 edge 24; invariants hold throughout.
- **Fault:** force `pwr_good`=0 for 1 cycle while ON → `pwr_fault`=1 two edges later and stays set; state stays ON; next `rst` clears it.
- **Reset mid-sequence:** assert `rst` in CLK_UP → all outputs at reset values after that edge; a subsequent req drop performs a normal power-down.
